// File: rtl/pixel_memory_responder_if.sv
// Bus bundle for the pixel memory responder: triple-address datapath port plus host streaming port.
interface pixel_memory_responder_if #(
    parameter int unsigned DATA_W = 18,
    parameter int unsigned ADDR_W = 10
);
    logic [ADDR_W-1:0]        a1m;
    logic [ADDR_W-1:0]        a2m;
    logic [ADDR_W-1:0]        a3m;
    logic [2:0][DATA_W-1:0]   write_data_m;
    logic                     mem_write_m;
    logic [2:0][DATA_W-1:0]   rdm;
    logic                     gpu_busy;
    logic [ADDR_W-1:0]        host_base;
    logic [ADDR_W:0]          host_len;
    logic                     host_start_load;
    logic                     host_start_dump;
    logic [DATA_W-1:0]        host_wdata;
    logic                     host_wvalid;
    logic                     host_wready;
    logic [DATA_W-1:0]        host_rdata;
    logic                     host_rvalid;
    logic                     host_rready;
    logic                     host_done;

    modport master (
        output a1m, a2m, a3m, write_data_m, mem_write_m,
        output host_base, host_len, host_start_load, host_start_dump,
        output host_wdata, host_wvalid, host_rready,
        input  rdm, gpu_busy, host_wready, host_rdata, host_rvalid, host_done
    );

    modport slave (
        input  a1m, a2m, a3m, write_data_m, mem_write_m,
        input  host_base, host_len, host_start_load, host_start_dump,
        input  host_wdata, host_wvalid, host_rready,
        output rdm, gpu_busy, host_wready, host_rdata, host_rvalid, host_done
    );
endinterface

// File: rtl/pixel_memory_responder.sv
// Three-lane pixel memory with combinational datapath reads and a host load/dump streaming port.
// A small FSM hands the memory to the host during transfers and locks out datapath writes.
module pixel_memory_responder #(
    parameter int unsigned DATA_W = 18,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pixel_memory_responder_if.slave  bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, LOAD, DUMP, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [CNT_W-1:0]        count_inc_c;
    logic [CNT_W-1:0]        len_q;
    logic [ADDR_W-1:0]       base_q;
    logic [ADDR_W-1:0]       host_addr_c;
    logic [ADDR_W-1:0]       next_addr_c;
    logic [ADDR_W-1:0]       rd_addr_c;
    logic [DATA_W-1:0]       rd_word_c;
    logic                    host_we_c;
    logic                    rd_load_c;
    logic                    dp_we_c;
    logic                    start_c;
    logic [2:0][ADDR_W-1:0]  dp_addr_c;
    logic [DATA_W-1:0]       mem [DEPTH];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    assign dp_addr_c   = {bus.a3m, bus.a2m, bus.a1m};
    assign dp_we_c     = bus.mem_write_m && (state_q == IDLE);
    assign start_c     = (state_q == IDLE) && (bus.host_start_load || bus.host_start_dump);
    assign count_inc_c = count_q + CNT_W'(1);
    assign host_addr_c = ADDR_W'(base_q + count_q[ADDR_W-1:0]);
    assign next_addr_c = ADDR_W'(host_addr_c + ADDR_W'(1));

    // Datapath reads are combinational in every state; out-of-range lanes read as zero.
    always_comb begin
        bus.rdm = '0;
        for (int i = 0; i < 3; i++) begin
            if (in_range(dp_addr_c[i])) bus.rdm[i] = mem[IDX_W'(dp_addr_c[i])];
        end
    end

    always_comb begin
        rd_word_c = '0;
        if (in_range(rd_addr_c)) rd_word_c = mem[IDX_W'(rd_addr_c)];
    end

    // Host writes and datapath writes are mutually exclusive by state; lane 0 is written last so it wins collisions.
    always_ff @(posedge clk) begin
        if (host_we_c && in_range(host_addr_c)) mem[IDX_W'(host_addr_c)] <= bus.host_wdata;
        if (dp_we_c && in_range(dp_addr_c[2])) mem[IDX_W'(dp_addr_c[2])] <= bus.write_data_m[2];
        if (dp_we_c && in_range(dp_addr_c[1])) mem[IDX_W'(dp_addr_c[1])] <= bus.write_data_m[1];
        if (dp_we_c && in_range(dp_addr_c[0])) mem[IDX_W'(dp_addr_c[0])] <= bus.write_data_m[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        host_we_c = 1'b0;
        rd_load_c = 1'b0;
        rd_addr_c = next_addr_c;
        case (state_q)
            IDLE: begin
                if (bus.host_start_load || bus.host_start_dump) begin
                    count_d = '0;
                    if (bus.host_len == '0) begin
                        state_d = DONE;
                    end else if (bus.host_start_load) begin
                        state_d = LOAD;
                    end else begin
                        state_d   = DUMP;
                        rd_load_c = 1'b1;
                        rd_addr_c = bus.host_base;
                    end
                end
            end
            LOAD: begin
                if (bus.host_wvalid) begin
                    host_we_c = 1'b1;
                    count_d   = count_inc_c;
                    if (count_inc_c == len_q) state_d = DONE;
                end
            end
            DUMP: begin
                // rvalid is held high for the whole DUMP state, so rready alone completes a beat.
                if (bus.host_rready) begin
                    count_d = count_inc_c;
                    if (count_inc_c == len_q) state_d = DONE;
                    else                      rd_load_c = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Transfer bookkeeping and registered host-side outputs, all derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q         <= '0;
            base_q          <= '0;
            len_q           <= '0;
            bus.gpu_busy    <= 1'b0;
            bus.host_wready <= 1'b0;
            bus.host_rvalid <= 1'b0;
            bus.host_done   <= 1'b0;
            bus.host_rdata  <= '0;
        end else begin
            count_q <= count_d;
            if (start_c) begin
                base_q <= bus.host_base;
                len_q  <= bus.host_len;
            end
            bus.gpu_busy    <= (state_d == LOAD) || (state_d == DUMP);
            bus.host_wready <= (state_d == LOAD);
            bus.host_rvalid <= (state_d == DUMP);
            bus.host_done   <= (state_d == DONE);
            if (rd_load_c) bus.host_rdata <= rd_word_c;
        end
    end
endmodule

// File: doc/pixel_memory_responder.md
Name: pixel_memory_responder

Overview:
- Data-memory responder for the three-lane (3x18-bit) filter datapath memory stage. Serves the datapath's triple-address port: A1, A2 = A1+1, A3 = A1-1 (neighbour pixels).
- Adds a host streaming port. It bulk-loads a source image before a filter run and dumps the result afterwards.
- A small FSM arbitrates the two ports. The datapath port is gated off while a host transfer is active.

Parameters:
DATA_W, 18, pixel/lane width
ADDR_W, 10, address width of A1M/A2M/A3M
DEPTH, 1024, number of words (must be ≤ 2^ADDR_W)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-low
A1M  in  ADDR_W  lane-0 address
A2M  in  ADDR_W  lane-1 address
A3M  in  ADDR_W  lane-2 address
writeDataM  in  3xDATA_W  lane data; lane0 goes to A1M, lane1 to A2M, lane2 to A3M
MemWriteM  in  1  datapath write enable
RDM  out  3xDATA_W  lane read data; lane0 from A1M, lane1 from A2M, lane2 from A3M
gpu_busy  out  1  high while a host transfer owns memory
host_base  in  ADDR_W  transfer start address, sampled at start
host_len  in  ADDR_W+1  word count, sampled at start
host_start_load  in  1  one-cycle start pulse for a load
host_start_dump  in  1  one-cycle start pulse for a dump
host_wdata  in  DATA_W  load data
host_wvalid  in  1  load data valid
host_wready  out  1  load data accepted when valid & ready
host_rdata  out  DATA_W  dump data
host_rvalid  out  1  dump data valid
host_rready  in  1  dump consumer ready
host_done  out  1  one-cycle pulse when a transfer completes

Behaviour:

Reset (RST low, asynchronous):
- state=IDLE, count=0.
- gpu_busy, host_wready, host_rvalid and host_done = 0; host_rdata = 0.
- Memory contents are not reset.
- Reset mid-transfer aborts it; words already loaded stay in memory.

Datapath port:
- Reads are combinational: RDM lane i = mem[addr_i] in the same cycle, in every state.
- Writes happen at the clock edge when MemWriteM=1 and state=IDLE; they are ignored otherwise (gpu_busy=1).
- Addresses ≥ DEPTH: the write is dropped and the read returns 0.
- If two lane addresses are equal, the lowest-numbered lane's write wins.

Address arithmetic:
- Host addressing is base+count modulo 2^ADDR_W.
- Accesses ≥ DEPTH are dropped on load and return 0 on dump.

FSM states: IDLE, LOAD, DUMP, DONE.
- IDLE:
  - host_start_load → LOAD; host_start_dump → DUMP. Both asserted together: load wins.
  - base and len are latched; count=0.
  - len=0 → go directly to DONE.
- LOAD:
  - host_wready=1, gpu_busy=1.
  - Each cycle with wvalid=1: mem[base+count] ← wdata, count++.
  - On the handshake where count reaches len: → DONE; wready drops the next cycle.
- DUMP:
  - At the edge that accepts the start pulse: host_rdata ← mem[base], host_rvalid ← 1.
  - Each cycle with rvalid & rready: count++, and host_rdata ← mem[base+count+1] at the same edge.
  - host_rdata and host_rvalid stay stable while rready=0.
  - After the handshake for word len-1: rvalid ← 0, → DONE.
  - gpu_busy=1 throughout.
- DONE:
  - host_done=1 for exactly one cycle, gpu_busy=0, then → IDLE.
- Start pulses outside IDLE are ignored.

Latency:
- Datapath read: 0 cycles.
- Load throughput: 1 word/cycle.
- Dump: first word valid 1 cycle after the start pulse; 1 word/cycle when rready is held high.

Test Plan:
1. Load 4 words (base=0x10, len=4, wvalid held high, data 1,2,3,4) → wready high for 4 cycles, host_done pulses 1 cycle later; then A1M=0x11 gives RDM = {2, 3, 1} (lanes 0/1/2).
2. Datapath write in IDLE with A1M=0x20, A2M=0x21, A3M=0x1F, data {0x3FFFF, 5, 7}, MemWriteM=1 → the next-cycle read returns the same data. Repeat the write during LOAD → memory unchanged, gpu_busy=1.
3. Dump of 3 words from 0x10 with rready toggling 1,0,1,1 → host_rdata sequence 1,2,3 with no duplicates or drops, data held stable while rready=0, host_done 1 cycle after the last handshake.
4. Simultaneous host_start_load and host_start_dump, and len=0 → load taken; with len=0, state goes IDLE→DONE→IDLE with no memory change and a single done pulse.
5. A1M=0 with A3M=0x3FF (wrap), and DEPTH=512 with an address of 0x300 → wrap address accessed correctly; out-of-range write dropped and its read returns 0.
6. RST asserted low mid-LOAD after 2 of 5 words → outputs immediately 0 and state IDLE; first 2 words retained; a new load then starts normally.
